// File: rtl/pim_indirect_addr_gen_if.sv
// pim_indirect_addr_gen_if: request/response channel between the indirect address generator and the memory arbiter
interface pim_indirect_addr_gen_if #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_is_idx;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_data;
    modport master (output req_valid, req_addr, req_is_idx, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, req_is_idx, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/pim_indirect_addr_gen.sv
// pim_indirect_addr_gen: walks an index table at A and issues gather addresses B + (idx << shift)
// Optional PIM_IDX_SENTINEL_EN: an all-ones index ends the run early.
module pim_indirect_addr_gen #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int IDX_PER_LINE = 8,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst_x,
    input  logic                      i_start,
    input  logic                      i_HPC_clear,
    input  logic [ADDR_W-1:0]         i_args_reg_A,
    input  logic [ADDR_W-1:0]         i_args_reg_B,
    input  logic [ADDR_W-1:0]         i_args_reg_C,
    pim_indirect_addr_gen_if.master   req,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [CNT_W-1:0]          o_gen_count
);
    localparam int S_W = $clog2(IDX_PER_LINE);
    typedef enum logic [2:0] {IDLE, IDX_REQ, IDX_WAIT, GEN, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]  rem_q, rem_d, cnt_q, cnt_d, l_q, l_d;
    logic [4:0]        sh_q, sh_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       idx;
    logic              sentinel;
    logic              req_valid, req_is_idx;
    logic [ADDR_W-1:0] req_addr;
    logic              unused_c;
    assign unused_c = ^i_args_reg_C[ADDR_W-1:21];
    assign idx = line_q[32*s_q +: 32];
`ifdef PIM_IDX_SENTINEL_EN
    assign sentinel = &idx;
`else
    assign sentinel = 1'b0;
`endif
    assign req.req_valid  = req_valid;
    assign req.req_is_idx = req_is_idx;
    assign req.req_addr   = req_addr;
    assign o_busy      = state_q != IDLE;
    assign o_done      = state_q == DONE;
    assign o_gen_count = cnt_q;
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        l_d        = l_q;
        sh_d       = sh_q;
        s_d        = s_q;
        line_d     = line_q;
        req_valid  = 1'b0;
        req_is_idx = 1'b0;
        req_addr   = '0;
        case (state_q)
            IDLE: if (i_start) begin
                a_d     = i_args_reg_A;
                b_d     = i_args_reg_B;
                rem_d   = i_args_reg_C[CNT_W-1:0];
                sh_d    = i_args_reg_C[20:16];
                cnt_d   = '0;
                l_d     = '0;
                s_d     = '0;
                state_d = i_args_reg_C[CNT_W-1:0] == '0 ? DONE : IDX_REQ;
            end
            IDX_REQ: begin
                req_valid  = 1'b1;
                req_is_idx = 1'b1;
                req_addr   = a_q + (ADDR_W'(l_q) << 5);
                if (req.req_ready) state_d = IDX_WAIT;
            end
            IDX_WAIT: if (req.rsp_valid) begin
                line_d  = req.rsp_data;
                s_d     = '0;
                state_d = GEN;
            end
            GEN: if (sentinel) state_d = DONE;
            else begin
                req_valid = 1'b1;
                req_addr  = b_q + (ADDR_W'(idx) << sh_q);
                if (req.req_ready) begin
                    rem_d = rem_q - CNT_W'(1);
                    cnt_d = cnt_q + CNT_W'(1);
                    s_d   = s_q + S_W'(1);
                    // the last slot of a line refetches unless the element budget is already exhausted
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                    else if (s_q == S_W'(IDX_PER_LINE - 1)) begin
                        l_d     = l_q + CNT_W'(1);
                        state_d = IDX_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_HPC_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            l_q     <= '0;
            sh_q    <= '0;
            s_q     <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            sh_q    <= sh_d;
            s_q     <= s_d;
            line_q  <= line_d;
        end
    end
endmodule

// File: tb/tb_pim_indirect_addr_gen.sv
// tb_pim_indirect_addr_gen: randomized scoreboard bench against an index-list reference model
module tb_pim_indirect_addr_gen;
    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        i_start = 1'b0;
    logic        i_HPC_clear = 1'b0;
    logic [31:0] a_r = '0, b_r = '0, c_r = '0;
    logic        o_busy, o_done;
    logic [15:0] o_gen_count;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] idx_mem [256];
    logic [32:0] exp_q [$];
    always #5 clk = ~clk;
    pim_indirect_addr_gen_if #(.ADDR_W(32), .LINE_W(256)) bus ();
    pim_indirect_addr_gen dut (
        .clk(clk), .rst_x(rst_x), .i_start(i_start), .i_HPC_clear(i_HPC_clear),
        .i_args_reg_A(a_r), .i_args_reg_B(b_r), .i_args_reg_C(c_r),
        .req(bus), .o_busy(o_busy), .o_done(o_done), .o_gen_count(o_gen_count)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [255:0] line_data(input int l);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = idx_mem[8*l + k];
        return r;
    endfunction
    task automatic fill_mem();
        for (int i = 0; i < 256; i++) idx_mem[i] = ($urandom % 10 == 0) ? 32'hFFFF_FFFF : $urandom;
    endtask
    // rmode: 0 ready held high, 1 ready toggles, 2 random; abort_at: accepted-request count at which to clear (-1 none)
    task automatic run_case(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input int rmode, input int abort_at);
        int n, sh, exp_cnt, acc, cyc, dly, fl, line;
        bit seen_done, pend, pv, pr, rdy;
        logic [32:0] prev, e;
        n = int'(c[15:0]); sh = int'(c[20:16]);
        exp_cnt = 0; acc = 0; cyc = 0; dly = 0; fl = 0; line = 0;
        seen_done = 0; pend = 0; pv = 0; pr = 0; prev = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i % 8 == 0) exp_q.push_back({1'b1, a + 32'(i / 8) * 32});
`ifdef PIM_IDX_SENTINEL_EN
            if (idx_mem[i] == 32'hFFFF_FFFF) break;
`endif
            exp_q.push_back({1'b0, b + (idx_mem[i] << sh)});
            exp_cnt++;
        end
        @(negedge clk);
        a_r = a; b_r = b; c_r = c; i_start = 1'b1;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            if (pv && !pr) begin
                check("hold_valid", bus.req_valid, 1);
                check("hold_addr", {bus.req_is_idx, bus.req_addr}, prev);
            end
            if (o_done) begin
                seen_done = 1;
                bus.req_ready = 1'b0;
                bus.rsp_valid = 1'b0;
                if (n == 0) check("zero_latency", cyc, 1);
                check("done_count", o_gen_count, exp_cnt);
                check("done_left", exp_q.size(), 0);
                check("done_busy", o_busy, 1);
                @(negedge clk);
                check("done_pulse", o_done, 0);
                check("idle_busy", o_busy, 0);
                check("count_hold", o_gen_count, exp_cnt);
            end else if (abort_at >= 0 && acc == abort_at) begin
                i_HPC_clear = 1'b1;
                bus.req_ready = 1'b0;
                bus.rsp_valid = 1'b0;
                @(negedge clk);
                i_HPC_clear = 1'b0;
                check("abort_valid", bus.req_valid, 0);
                check("abort_busy", o_busy, 0);
                check("abort_done", o_done, 0);
                check("abort_count", o_gen_count, 0);
                bus.rsp_valid = 1'b1;
                bus.rsp_data = line_data(line);
                bus.req_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    bus.rsp_valid = 1'b0;
                    check("late_rsp_valid", bus.req_valid, 0);
                    check("late_rsp_done", o_done, 0);
                end
                bus.req_ready = 1'b0;
                return;
            end else begin
                if (pend && dly == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data = line_data(line);
                    pend = 0;
                end else begin
                    if (pend) dly--;
                    bus.rsp_valid = !pend && ($urandom % 4 == 0);
                    bus.rsp_data = {8{$urandom}};
                end
                rdy = rmode == 0 ? 1'b1 : rmode == 1 ? cyc[0] : 1'($urandom % 2);
                bus.req_ready = rdy;
                if (bus.req_valid && rdy) begin
                    if (exp_q.size() == 0) check("extra_req", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        check(e[32] ? "idx_fetch" : "data_req", {bus.req_is_idx, bus.req_addr}, e);
                    end
                    acc++;
                    if (bus.req_is_idx) begin
                        pend = 1; dly = $urandom % 3; line = fl; fl++;
                    end
                end
                pv = bus.req_valid; pr = rdy; prev = {bus.req_is_idx, bus.req_addr};
                i_start = ($urandom % 16 == 0);
                a_r = $urandom; b_r = $urandom; c_r = $urandom;
            end
        end
        i_start = 1'b0;
        check("finished_in_time", seen_done, 1);
    endtask
    initial begin
        logic [31:0] a, b;
        int n, sh;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.req_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_count", o_gen_count, 0);
        rst_x = 1'b1;
        fill_mem();
        idx_mem[0] = 5; idx_mem[1] = 0; idx_mem[2] = 7;
        run_case(32'h1000, 32'h8000, 32'h0002_0003, 0, -1);
        run_case(32'h1000, 32'h8000, 32'h0002_0003, 1, -1);
        fill_mem();
        for (int i = 0; i < 10; i++) idx_mem[i] = $urandom_range(0, 1000);
        run_case(32'h2000, 32'h4000, 32'd10, 0, -1);
        run_case(32'h2000, 32'h4000, 32'hFFE0_0000, 0, -1);
        run_case(32'h3000, 32'h0100, 32'd10, 0, 1);
        fill_mem();
        idx_mem[0] = 1; idx_mem[1] = 2; idx_mem[2] = 32'hFFFF_FFFF;
        run_case(32'h0, 32'h0, 32'h0004_0005, 0, -1);
        for (int t = 0; t < 30; t++) begin
            fill_mem();
            a = $urandom; b = $urandom;
            n = $urandom_range(0, 40); sh = $urandom_range(0, 31);
            run_case(a, b, {11'($urandom), 5'(sh), 16'(n)}, $urandom_range(0, 2),
                     ($urandom % 5 == 0) ? $urandom_range(0, n) : -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
